// File: rtl/can_fault_confinement_if.sv
// Interface between the error detectors / protocol controller and the CAN
// fault-confinement unit.
//   master : error detectors + controller side (drives events, reads status)
//   slave  : fault-confinement unit (reads events, drives status)
// Events: sample_point, rx_bit, tx_active, bit/stuff/form/crc/ack_error,
//         rx_dom_after_flag, tx_success, rx_success
//         (+ recovery_req when CAN_HOST_RECOVERY_REQ_EN is defined)
// Status: tec, rec, error_active, error_passive, bus_off, error_warning,
//         bus_off_recovered
interface can_fault_confinement_if #(
  parameter int TEC_W = 9,
  parameter int REC_W = 8
) ();
  logic             sample_point;
  logic             rx_bit;
  logic             tx_active;
  logic             bit_error;
  logic             stuff_error;
  logic             form_error;
  logic             crc_error;
  logic             ack_error;
  logic             rx_dom_after_flag;
  logic             tx_success;
  logic             rx_success;
`ifdef CAN_HOST_RECOVERY_REQ_EN
  logic             recovery_req;
`endif
  logic [TEC_W-1:0] tec;
  logic [REC_W-1:0] rec;
  logic             error_active;
  logic             error_passive;
  logic             bus_off;
  logic             error_warning;
  logic             bus_off_recovered;

  modport master (
    output sample_point, rx_bit, tx_active, bit_error, stuff_error, form_error,
           crc_error, ack_error, rx_dom_after_flag, tx_success, rx_success,
`ifdef CAN_HOST_RECOVERY_REQ_EN
           recovery_req,
`endif
    input  tec, rec, error_active, error_passive, bus_off, error_warning,
           bus_off_recovered
  );

  modport slave (
    input  sample_point, rx_bit, tx_active, bit_error, stuff_error, form_error,
           crc_error, ack_error, rx_dom_after_flag, tx_success, rx_success,
`ifdef CAN_HOST_RECOVERY_REQ_EN
           recovery_req,
`endif
    output tec, rec, error_active, error_passive, bus_off, error_warning,
           bus_off_recovered
  );
endinterface

// File: rtl/can_fault_confinement.sv
// CAN fault-confinement unit: TEC/REC counters with +8/+1/-1 weighting,
// ERROR_ACTIVE / ERROR_PASSIVE / BUS_OFF node state, warning flag and
// bus-off recovery by counting 11-recessive-bit idle sequences.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous reset, active-low
//   bus  - can_fault_confinement_if.slave (event pulses in, counters/status out)
//
// Optional feature (macro CAN_HOST_RECOVERY_REQ_EN):
//   defined   - bus.recovery_req must pulse (on or after BUS_OFF entry) before
//               recovery sequences are counted.
//   undefined - recovery counting starts on the first sample point in BUS_OFF.
module can_fault_confinement #(
  parameter int TEC_W        = 9,
  parameter int REC_W        = 8,
  parameter int WARN_TH      = 96,
  parameter int PASSIVE_TH   = 128,
  parameter int BUSOFF_TH    = 256,
  parameter int REC_RESTORE  = 120,
  parameter int IDLE_BITS    = 11,
  parameter int RECOVERY_CNT = 128
) (
  input logic                  clk,
  input logic                  rst,
  can_fault_confinement_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_PASSIVE = 2'd1,
    ST_BUSOFF  = 2'd2
  } state_e;

  localparam int IDLE_W = $clog2(IDLE_BITS + 1);
  localparam int SEQ_W  = $clog2(RECOVERY_CNT + 1);

  localparam logic [TEC_W-1:0]  TEC_WARN    = TEC_W'(WARN_TH);
  localparam logic [TEC_W-1:0]  TEC_PASSIVE = TEC_W'(PASSIVE_TH);
  localparam logic [TEC_W-1:0]  TEC_BUSOFF  = TEC_W'(BUSOFF_TH);
  localparam logic [REC_W-1:0]  REC_WARN    = REC_W'(WARN_TH);
  localparam logic [REC_W-1:0]  REC_PASSIVE = REC_W'(PASSIVE_TH);
  localparam logic [REC_W-1:0]  REC_LOAD    = REC_W'(REC_RESTORE);
  localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(IDLE_BITS - 1);
  localparam logic [SEQ_W-1:0]  SEQ_LAST    = SEQ_W'(RECOVERY_CNT - 1);

  state_e            state_q, state_d;
  logic [TEC_W-1:0]  tec_q, tec_d;
  logic [REC_W-1:0]  rec_q, rec_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              warn_q, warn_d;
  logic              recov_q, recov_d;
  logic              run_recovery;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic any_err, err_evt, tx_err, ack_only, tec_inc, rx_err, rx_dom;
  logic [TEC_W:0] tec_sum;
  logic [REC_W:0] rec_add, rec_sum;
  logic [TEC_W-1:0] tec_sat;
  logic [REC_W-1:0] rec_sat;

  assign any_err  = bus.bit_error | bus.stuff_error | bus.form_error |
                    bus.crc_error | bus.ack_error;
  // Any error-type pulse pre-empts a same-cycle success pulse.
  assign err_evt  = any_err | bus.rx_dom_after_flag;
  // crc_error does not count against a transmitter.
  assign tx_err   = bus.tx_active &
                    (bus.bit_error | bus.stuff_error | bus.form_error | bus.ack_error);
  assign ack_only = bus.ack_error & ~(bus.bit_error | bus.stuff_error | bus.form_error);
  // A passive transmitter that only misses the ACK keeps its TEC.
  assign tec_inc  = tx_err & ~((state_q == ST_PASSIVE) & ack_only);
  assign rx_err   = ~bus.tx_active & any_err;
  assign rx_dom   = ~bus.tx_active & bus.rx_dom_after_flag;

  // One extra bit of headroom detects overflow for saturation.
  assign tec_sum  = {1'b0, tec_q} + (TEC_W+1)'(8);
  assign tec_sat  = tec_sum[TEC_W] ? '1 : tec_sum[TEC_W-1:0];
  // Receiver increment is 0, 1, 8 or 9.
  assign rec_add  = {{(REC_W-3){1'b0}}, rx_dom, 2'b00, rx_err};
  assign rec_sum  = {1'b0, rec_q} + rec_add;
  assign rec_sat  = rec_sum[REC_W] ? '1 : rec_sum[REC_W-1:0];

`ifdef CAN_HOST_RECOVERY_REQ_EN
  logic arm_q, arm_d;
  // Armed while (about to be) in BUS_OFF once a request has been seen; the
  // entry cycle counts because state_d is already BUS_OFF there.
  assign arm_d        = (state_d == ST_BUSOFF) & (arm_q | bus.recovery_req);
  assign run_recovery = arm_q;
`else
  assign run_recovery = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    tec_d   = tec_q;
    rec_d   = rec_q;
    idle_d  = '0;
    seq_d   = '0;
    recov_d = 1'b0;

    if (state_q == ST_BUSOFF) begin
      // Counters frozen; only the recessive-sequence counters advance.
      idle_d = idle_q;
      seq_d  = seq_q;
      if (run_recovery && bus.sample_point) begin
        if (!bus.rx_bit) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          idle_d = '0;
          if (seq_q == SEQ_LAST) begin
            seq_d   = '0;
            tec_d   = '0;
            rec_d   = '0;
            state_d = ST_ACTIVE;
            recov_d = 1'b1;
          end else begin
            seq_d = seq_q + SEQ_W'(1);
          end
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
    end else begin
      if (err_evt) begin
        if (tec_inc) tec_d = tec_sat;
        rec_d = rec_sat;
      end else begin
        if (bus.tx_success && tec_q != '0) tec_d = tec_q - TEC_W'(1);
        if (bus.rx_success) begin
          if (rec_q >= REC_PASSIVE)  rec_d = REC_LOAD;
          else if (rec_q != '0)      rec_d = rec_q - REC_W'(1);
        end
      end

      // Status follows the new counter values on the same edge.
      if (tec_d >= TEC_BUSOFF)                           state_d = ST_BUSOFF;
      else if (tec_d >= TEC_PASSIVE || rec_d >= REC_PASSIVE) state_d = ST_PASSIVE;
      else                                               state_d = ST_ACTIVE;
    end

    warn_d = (tec_d >= TEC_WARN) | (rec_d >= REC_WARN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ACTIVE;
      tec_q   <= '0;
      rec_q   <= '0;
      idle_q  <= '0;
      seq_q   <= '0;
      warn_q  <= 1'b0;
      recov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tec_q   <= tec_d;
      rec_q   <= rec_d;
      idle_q  <= idle_d;
      seq_q   <= seq_d;
      warn_q  <= warn_d;
      recov_q <= recov_d;
    end
  end

`ifdef CAN_HOST_RECOVERY_REQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) arm_q <= 1'b0;
    else      arm_q <= arm_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.tec               = tec_q;
  assign bus.rec               = rec_q;
  assign bus.error_active      = (state_q == ST_ACTIVE);
  assign bus.error_passive     = (state_q == ST_PASSIVE);
  assign bus.bus_off           = (state_q == ST_BUSOFF);
  assign bus.error_warning     = warn_q;
  assign bus.bus_off_recovered = recov_q;

endmodule

// File: tb/tb_can_fault_confinement.sv
module tb_can_fault_confinement;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Event mask bit positions for ev()
  localparam logic [7:0] E_BIT = 8'h80, E_STUFF = 8'h40, E_FORM = 8'h20,
                         E_CRC = 8'h10, E_ACK = 8'h08, E_DOM = 8'h04,
                         E_TXS = 8'h02, E_RXS = 8'h01;

  can_fault_confinement_if #(.TEC_W(9), .REC_W(8)) bus ();

  can_fault_confinement dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic txa, input logic [7:0] m);
    bus.tx_active         = txa;
    bus.bit_error         = m[7];
    bus.stuff_error       = m[6];
    bus.form_error        = m[5];
    bus.crc_error         = m[4];
    bus.ack_error         = m[3];
    bus.rx_dom_after_flag = m[2];
    bus.tx_success        = m[1];
    bus.rx_success        = m[0];
  endtask

  // n consecutive one-cycle event pulses; returns at a negedge after the last edge
  task automatic ev(input int n, input logic txa, input logic [7:0] m);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(txa, m);
    end
    @(negedge clk);
    drive(1'b0, 8'h00);
  endtask

  task automatic bits(input int n, input logic val);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.sample_point = 1'b1;
      bus.rx_bit       = val;
    end
    @(negedge clk);
    bus.sample_point = 1'b0;
    bus.rx_bit       = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

`ifdef CAN_HOST_RECOVERY_REQ_EN
  task automatic req();
    @(negedge clk);
    bus.recovery_req = 1'b1;
    @(negedge clk);
    bus.recovery_req = 1'b0;
  endtask
`endif

  initial begin
    bus.sample_point = 1'b0;
    bus.rx_bit       = 1'b1;
`ifdef CAN_HOST_RECOVERY_REQ_EN
    bus.recovery_req = 1'b0;
`endif
    drive(1'b0, 8'h00);

    // Reset state
    #2;
    chk("rst_tec", bus.tec, 0);
    chk("rst_rec", bus.rec, 0);
    chk("rst_active", bus.error_active, 1);
    chk("rst_passive", bus.error_passive, 0);
    chk("rst_busoff", bus.bus_off, 0);
    chk("rst_warn", bus.error_warning, 0);
    chk("rst_recov", bus.bus_off_recovered, 0);
    @(negedge clk);
    rst = 1'b1;

    // Transmit errors: warning at 96, passive at 128
    ev(1, 1'b1, E_TXS);
    chk("txs_at0", bus.tec, 0);
    ev(12, 1'b1, E_BIT);
    chk("tec96", bus.tec, 96);
    chk("warn96", bus.error_warning, 1);
    chk("active96", bus.error_active, 1);
    ev(3, 1'b1, E_BIT);
    chk("tec120", bus.tec, 120);
    chk("active120", bus.error_active, 1);
    ev(1, 1'b1, E_ACK);
    chk("tec128_ack", bus.tec, 128);
    chk("passive128", bus.error_passive, 1);
    ev(1, 1'b1, E_ACK);
    chk("ack_passive_hold", bus.tec, 128);
    ev(1, 1'b1, E_TXS);
    chk("tec127", bus.tec, 127);
    chk("active127", bus.error_active, 1);
    chk("warn127", bus.error_warning, 1);
    ev(1, 1'b1, E_CRC);
    chk("tx_crc_ignored", bus.tec, 127);
    chk("tx_crc_rec", bus.rec, 0);

    // Receive errors, restore, +9, saturation
    do_reset();
    chk("reset2_tec", bus.tec, 0);
    ev(1, 1'b0, E_RXS);
    chk("rxs_at0", bus.rec, 0);
    ev(130, 1'b0, E_STUFF);
    chk("rec130", bus.rec, 130);
    chk("rec_passive", bus.error_passive, 1);
    ev(1, 1'b0, E_RXS);
    chk("rec_restore", bus.rec, 120);
    chk("rec_active", bus.error_active, 1);
    chk("rec_warn", bus.error_warning, 1);
    ev(1, 1'b0, E_STUFF | E_DOM);
    chk("rec_plus9", bus.rec, 129);
    ev(16, 1'b0, E_DOM);
    chk("rec_sat", bus.rec, 255);
    ev(1, 1'b0, E_CRC);
    chk("rec_sat_crc", bus.rec, 255);
    chk("rec_sat_tec", bus.tec, 0);

    // Error and success together: error wins
    do_reset();
    ev(2, 1'b1, E_BIT);
    ev(6, 1'b1, E_TXS);
    chk("tec10", bus.tec, 10);
    ev(1, 1'b1, E_FORM | E_TXS);
    chk("err_beats_success", bus.tec, 18);

    // Bus-off entry, freeze, recovery
    do_reset();
    ev(5, 1'b0, E_STUFF);
    ev(31, 1'b1, E_BIT);
    chk("tec248", bus.tec, 248);
    chk("passive248", bus.error_passive, 1);
    ev(1, 1'b1, E_BIT);
    chk("tec256", bus.tec, 256);
    chk("busoff", bus.bus_off, 1);
    chk("busoff_not_passive", bus.error_passive, 0);
    ev(3, 1'b1, E_BIT | E_STUFF);
    ev(3, 1'b0, E_RXS | E_DOM);
    ev(3, 1'b1, E_TXS);
    chk("frozen_tec", bus.tec, 256);
    chk("frozen_rec", bus.rec, 5);
`ifdef CAN_HOST_RECOVERY_REQ_EN
    bits(2000, 1'b1);
    chk("no_req_busoff", bus.bus_off, 1);
    req();
`endif
    bits(660, 1'b1);
    bits(5, 1'b1);
    bits(1, 1'b0);
    bits(747, 1'b1);
    chk("pre_recov_busoff", bus.bus_off, 1);
    chk("pre_recov_tec", bus.tec, 256);
    chk("pre_recov_pulse", bus.bus_off_recovered, 0);
    bits(1, 1'b1);
    chk("recov_active", bus.error_active, 1);
    chk("recov_tec", bus.tec, 0);
    chk("recov_rec", bus.rec, 0);
    chk("recov_pulse", bus.bus_off_recovered, 1);
    chk("recov_warn", bus.error_warning, 0);
    @(negedge clk);
    chk("recov_pulse_end", bus.bus_off_recovered, 0);

    // Reset in the middle of recovery
    ev(32, 1'b1, E_BIT);
    chk("busoff2", bus.bus_off, 1);
`ifdef CAN_HOST_RECOVERY_REQ_EN
    req();
`endif
    bits(660, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busoff", bus.bus_off, 0);
    chk("midrst_active", bus.error_active, 1);
    chk("midrst_tec", bus.tec, 0);
    chk("midrst_warn", bus.error_warning, 0);
    @(negedge clk);
    rst = 1'b1;
    ev(1, 1'b1, E_BIT);
    chk("post_rst_tec", bus.tec, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
